// File: rtl/bus_matrix_slave_arbiter.sv
// Per-slave-port round-robin arbiter for the bus matrix.
// Grants one requesting master and holds the grant until the slave reports done.
// On release, priority rotates to the master after the owner, and a new owner can be
// granted on the same edge, so there is no idle cycle between owners.
// Optional watchdog: define BUS_MATRIX_ARB_TIMEOUT_EN to force-release a grant that
// stays open for TIMEOUT_CYCLES cycles without done_i. When the macro is not defined,
// timeout_o is tied to 0.
module bus_matrix_slave_arbiter #(
  parameter int unsigned N_MASTERS      = 2,
  parameter int unsigned IDX_W          = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [N_MASTERS-1:0] req_i,
  input  logic [N_MASTERS-1:0] lock_i,
  input  logic                 done_i,
  output logic [N_MASTERS-1:0] gnt_o,
  output logic [IDX_W-1:0]     gnt_idx_o,
  output logic                 gnt_valid_o,
  output logic                 timeout_o
);

  if (N_MASTERS < 1 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("bus_matrix_slave_arbiter: need N_MASTERS >= 1 and TIMEOUT_CYCLES >= 2");
  end

  typedef enum logic {StIdle, StBusy} state_e;

  state_e                 state;
  logic [IDX_W-1:0]       ptr;
  logic [IDX_W-1:0]       owner_inc;
  logic [IDX_W-1:0]       scan_base;
  logic [IDX_W-1:0]       pick;
  logic [IDX_W-1:0]       cand;
  logic [N_MASTERS-1:0]   pick_onehot;
  logic                   found;
  logic                   owner_keeps;
  logic                   release_grant;
  logic                   wd_expire;

  // The owner's successor is both the new priority pointer and the scan start
  // on release, so the current owner is scanned last.
  assign owner_inc     = (gnt_idx_o == IDX_W'(N_MASTERS - 1)) ? '0 : gnt_idx_o + 1'b1;
  assign owner_keeps   = lock_i[gnt_idx_o] & req_i[gnt_idx_o];
  assign release_grant = (state == StBusy) & ((done_i & ~owner_keeps) | wd_expire);
  assign scan_base     = (state == StIdle) ? ptr : owner_inc;

  // Pick the first requester at or after scan_base, wrapping modulo N_MASTERS.
  always_comb begin
    found       = 1'b0;
    pick        = '0;
    cand        = '0;
    pick_onehot = '0;
    for (int unsigned i = 0; i < N_MASTERS; i++) begin
      cand = IDX_W'((32'(scan_base) + i) % N_MASTERS);
      if (!found && req_i[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
    pick_onehot[pick] = 1'b1;
  end

  // Grant FSM: registered grant outputs and the rotating priority pointer.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state       <= StIdle;
      ptr         <= '0;
      gnt_o       <= '0;
      gnt_idx_o   <= '0;
      gnt_valid_o <= 1'b0;
    end else begin
      case (state)
        StIdle: begin
          if (found) begin
            state       <= StBusy;
            gnt_o       <= pick_onehot;
            gnt_idx_o   <= pick;
            gnt_valid_o <= 1'b1;
          end
        end
        StBusy: begin
          if (release_grant) begin
            ptr <= owner_inc;
            if (found) begin
              gnt_o     <= pick_onehot;
              gnt_idx_o <= pick;
            end else begin
              state       <= StIdle;
              gnt_o       <= '0;
              gnt_valid_o <= 1'b0;
            end
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

`ifdef BUS_MATRIX_ARB_TIMEOUT_EN
  localparam int unsigned WD_W = ($clog2(TIMEOUT_CYCLES) > 0) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [WD_W-1:0] wd_cnt;
  logic            timeout_q;

  assign wd_expire = (state == StBusy) & ~done_i & (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
  assign timeout_o = timeout_q;

  // Watchdog: counts open BUSY cycles; any release, done or idle cycle restarts it.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wd_cnt    <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= wd_expire;
      if (state != StBusy || done_i || release_grant) begin
        wd_cnt <= '0;
      end else begin
        wd_cnt <= wd_cnt + 1'b1;
      end
    end
  end
`else
  assign wd_expire = 1'b0;
  assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_bus_matrix_slave_arbiter.sv
// Bench for bus_matrix_slave_arbiter: a 2-master instance driven from a vector table,
// plus a 4-master instance for the pointer-wrap sequence. Expected outputs are queued
// when each stimulus is driven and are compared #1 after the following rising edge.
module tb_bus_matrix_slave_arbiter;

  localparam int unsigned TO = 8;

  logic       clk = 1'b0;
  logic       rst2_n, done2, valid2, to2;
  logic [1:0] req2, lock2, gnt2;
  logic [0:0] idx2;
  logic       rst4_n, done4, valid4, to4;
  logic [3:0] req4, lock4, gnt4;
  logic [1:0] idx4;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  bus_matrix_slave_arbiter #(.N_MASTERS(2), .TIMEOUT_CYCLES(TO)) u_arb2 (
    .clk_i(clk), .rst_ni(rst2_n), .req_i(req2), .lock_i(lock2), .done_i(done2),
    .gnt_o(gnt2), .gnt_idx_o(idx2), .gnt_valid_o(valid2), .timeout_o(to2)
  );

  bus_matrix_slave_arbiter #(.N_MASTERS(4), .TIMEOUT_CYCLES(TO)) u_arb4 (
    .clk_i(clk), .rst_ni(rst4_n), .req_i(req4), .lock_i(lock4), .done_i(done4),
    .gnt_o(gnt4), .gnt_idx_o(idx4), .gnt_valid_o(valid4), .timeout_o(to4)
  );

  typedef struct {
    string      name;
    logic       rst_n;
    logic [1:0] req;
    logic [1:0] lock;
    logic       done;
    logic [1:0] gnt;
    logic       valid;
    logic       idx;
  } vec_t;

  typedef struct {
    string      name;
    bit         sel4;
    logic [3:0] gnt;
    logic       valid;
    logic [1:0] idx;
    logic       to;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  function automatic vec_t mk(input string n, input logic r, input logic [1:0] q,
                              input logic [1:0] l, input logic d, input logic [1:0] g,
                              input logic v, input logic i);
    vec_t t;
    t.name = n; t.rst_n = r; t.req = q; t.lock = l; t.done = d;
    t.gnt = g; t.valid = v; t.idx = i;
    return t;
  endfunction

  task automatic check_one();
    exp_t       e;
    logic [7:0] act, want;
    n_vec++;
    if (sb.size() == 0) begin
      n_bad++;
      $display("FAIL scoreboard: no expected entry queued");
    end else begin
      e    = sb.pop_front();
      want = {e.gnt, e.valid, e.idx, e.to};
      act  = e.sel4 ? {gnt4, valid4, idx4, to4} : {2'b00, gnt2, valid2, 1'b0, idx2, to2};
      if (act !== want) begin
        n_bad++;
        $display("FAIL %s: got gnt=%b valid=%b idx=%0d to=%b, want gnt=%b valid=%b idx=%0d to=%b",
                 e.name, act[7:4], act[3], act[2:1], act[0], want[7:4], want[3], want[2:1],
                 want[0]);
      end
    end
  endtask

  task automatic step2(input string n, input logic r, input logic [1:0] q,
                       input logic [1:0] l, input logic d, input logic [1:0] g,
                       input logic v, input logic i, input logic t);
    exp_t e;
    @(negedge clk);
    rst2_n = r; req2 = q; lock2 = l; done2 = d;
    e.name = n; e.sel4 = 1'b0; e.gnt = {2'b00, g}; e.valid = v; e.idx = {1'b0, i}; e.to = t;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check_one();
  endtask

  task automatic step4(input string n, input logic r, input logic [3:0] q,
                       input logic d, input logic [3:0] g, input logic v,
                       input logic [1:0] i);
    exp_t e;
    @(negedge clk);
    rst4_n = r; req4 = q; lock4 = 4'b0000; done4 = d;
    e.name = n; e.sel4 = 1'b1; e.gnt = g; e.valid = v; e.idx = i; e.to = 1'b0;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check_one();
  endtask

  initial begin
    rst2_n = 1'b0; req2 = '0; lock2 = '0; done2 = 1'b0;
    rst4_n = 1'b0; req4 = '0; lock4 = '0; done4 = 1'b0;

    //                name           rst  req    lock   done gnt    vld  idx
    vecs.push_back(mk("reset",       0, 2'b00, 2'b00, 0, 2'b00, 0, 0));
    vecs.push_back(mk("idle",        1, 2'b00, 2'b00, 0, 2'b00, 0, 0));
    vecs.push_back(mk("first_gnt",   1, 2'b11, 2'b00, 0, 2'b01, 1, 0));
    vecs.push_back(mk("no_bubble",   1, 2'b11, 2'b00, 1, 2'b10, 1, 1));
    vecs.push_back(mk("wrap_to_0",   1, 2'b11, 2'b00, 1, 2'b01, 1, 0));
    vecs.push_back(mk("lock_1",      1, 2'b11, 2'b01, 1, 2'b01, 1, 0));
    vecs.push_back(mk("lock_2",      1, 2'b11, 2'b01, 1, 2'b01, 1, 0));
    vecs.push_back(mk("lock_3",      1, 2'b11, 2'b01, 1, 2'b01, 1, 0));
    vecs.push_back(mk("unlock_rot",  1, 2'b11, 2'b00, 1, 2'b10, 1, 1));
    vecs.push_back(mk("drop_hold_a", 1, 2'b01, 2'b00, 0, 2'b10, 1, 1));
    vecs.push_back(mk("drop_hold_b", 1, 2'b00, 2'b00, 0, 2'b10, 1, 1));
    vecs.push_back(mk("done_idle",   1, 2'b00, 2'b00, 1, 2'b00, 0, 1));
    vecs.push_back(mk("idle_done",   1, 2'b00, 2'b00, 1, 2'b00, 0, 1));
    vecs.push_back(mk("scan_skip",   1, 2'b10, 2'b00, 0, 2'b10, 1, 1));
    vecs.push_back(mk("lock_keep",   1, 2'b10, 2'b10, 1, 2'b10, 1, 1));
    vecs.push_back(mk("lock_noreq",  1, 2'b01, 2'b10, 1, 2'b01, 1, 0));
    vecs.push_back(mk("busy_hold",   1, 2'b11, 2'b00, 0, 2'b01, 1, 0));
    vecs.push_back(mk("rot_again",   1, 2'b11, 2'b00, 1, 2'b10, 1, 1));
    vecs.push_back(mk("rst_busy",    0, 2'b11, 2'b00, 0, 2'b00, 0, 0));
    vecs.push_back(mk("ptr_reset",   1, 2'b11, 2'b00, 0, 2'b01, 1, 0));
    vecs.push_back(mk("rel_idle",    1, 2'b00, 2'b00, 1, 2'b00, 0, 0));
    vecs.push_back(mk("idle_rot",    1, 2'b11, 2'b00, 0, 2'b10, 1, 1));
    vecs.push_back(mk("rel_idle2",   1, 2'b00, 2'b00, 1, 2'b00, 0, 1));

    foreach (vecs[k]) begin
      step2(vecs[k].name, vecs[k].rst_n, vecs[k].req, vecs[k].lock, vecs[k].done,
            vecs[k].gnt, vecs[k].valid, vecs[k].idx, 1'b0);
    end

    // Four masters: owner 3 releases and the pointer wraps to master 0.
    step4("n4_reset", 0, 4'b0000, 0, 4'b0000, 0, 2'd0);
    step4("n4_gnt3",  1, 4'b1000, 0, 4'b1000, 1, 2'd3);
    step4("n4_wrap",  1, 4'b1001, 1, 4'b0001, 1, 2'd0);
    step4("n4_rot1",  1, 4'b1110, 1, 4'b0010, 1, 2'd1);
    step4("n4_rot2",  1, 4'b1101, 1, 4'b0100, 1, 2'd2);
    step4("n4_idle",  1, 4'b0000, 1, 4'b0000, 0, 2'd2);
    step4("n4_scan3", 1, 4'b0011, 0, 4'b0001, 1, 2'd0);

    // Grant left open without done_i.
    step2("open_gnt", 1, 2'b11, 2'b01, 0, 2'b01, 1, 0, 0);
`ifdef BUS_MATRIX_ARB_TIMEOUT_EN
    for (int c = 0; c < int'(TO) - 1; c++) begin
      step2("wd_hold", 1, 2'b11, 2'b01, 0, 2'b01, 1, 0, 0);
    end
    step2("wd_fire",  1, 2'b11, 2'b01, 0, 2'b10, 1, 1, 1);
    step2("wd_pulse", 1, 2'b11, 2'b00, 0, 2'b10, 1, 1, 0);
    step2("wd_idle",  1, 2'b00, 2'b00, 1, 2'b00, 0, 1, 0);
`else
    for (int c = 0; c < 120; c++) begin
      step2("long_hold", 1, 2'b11, 2'b01, 0, 2'b01, 1, 0, 0);
    end
    step2("late_done", 1, 2'b11, 2'b00, 1, 2'b10, 1, 1, 0);
    step2("end_idle",  1, 2'b00, 2'b00, 1, 2'b00, 0, 1, 0);
`endif

    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
